// File: rtl/rr_arbiter3.sv
// Round-robin arbiter for three clients sharing one resource.
// Grants are registered and one-hot. The owner keeps the grant while it holds req high,
// for at most MAX_HOLD cycles. Every release is followed by one GAP cycle with no grant,
// then one IDLE cycle in which the next owner is picked.
module rr_arbiter3 #(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             any_req,
  output logic             timeout
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_e             r_state, w_state_d;
  logic [N_REQ-1:0]   r_gnt, w_gnt_d;
  logic [1:0]         r_owner, w_owner_d;
  logic               r_busy, w_busy_d;
  logic               r_timeout, w_timeout_d;
  logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_d;
  logic [1:0]         r_last, w_last_d;
  logic               w_any_req;
  logic [1:0]         w_pick;
  logic [N_REQ-1:0]   w_pick_onehot;

  assign w_any_req     = ~(~req[0] & ~req[1] & ~req[2]);
  assign w_pick_onehot = N_REQ'(3'b001 << w_pick);

  // Pick the first requester after the last owner, wrapping modulo 3.
  always_comb begin
    w_pick = 2'd0;
    unique case (r_last)
      2'd0: begin
        if (req[1])      w_pick = 2'd1;
        else if (req[2]) w_pick = 2'd2;
        else             w_pick = 2'd0;
      end
      2'd1: begin
        if (req[2])      w_pick = 2'd2;
        else if (req[0]) w_pick = 2'd0;
        else             w_pick = 2'd1;
      end
      default: begin
        if (req[0])      w_pick = 2'd0;
        else if (req[1]) w_pick = 2'd1;
        else             w_pick = 2'd2;
      end
    endcase
  end

  // State and registered outputs; reset returns priority to client 0 (last = 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_gnt      <= '0;
      r_owner    <= 2'd0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
      r_last     <= 2'd2;
    end else begin
      r_state    <= w_state_d;
      r_gnt      <= w_gnt_d;
      r_owner    <= w_owner_d;
      r_busy     <= w_busy_d;
      r_timeout  <= w_timeout_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_last     <= w_last_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold or release in GRANT, one turnaround in GAP.
  always_comb begin
    w_state_d    = r_state;
    w_gnt_d      = r_gnt;
    w_owner_d    = r_owner;
    w_busy_d     = r_busy;
    w_timeout_d  = 1'b0;  // pulse lasts only for the GAP cycle after a forced release
    w_hold_cnt_d = r_hold_cnt;
    w_last_d     = r_last;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_gnt_d      = w_pick_onehot;
          w_owner_d    = w_pick;
          w_busy_d     = 1'b1;
          w_hold_cnt_d = '0;
          w_state_d    = StGrant;
        end
      end
      StGrant: begin
        // A voluntary release wins over a forced release on the same edge.
        if (!req[r_owner]) begin
          w_gnt_d   = '0;
          w_busy_d  = 1'b0;
          w_last_d  = r_owner;
          w_state_d = StGap;
        end else if (r_hold_cnt == HoldLast) begin
          w_gnt_d     = '0;
          w_busy_d    = 1'b0;
          w_last_d    = r_owner;
          w_timeout_d = 1'b1;
          w_state_d   = StGap;
        end else begin
          w_hold_cnt_d = r_hold_cnt + CNT_W'(1);
        end
      end
      StGap: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Outputs come straight from registers, apart from the combinational any_req.
  always_comb begin
    gnt     = r_gnt;
    owner   = r_owner;
    busy    = r_busy;
    timeout = r_timeout;
    any_req = w_any_req;
  end

endmodule

// File: tb/tb_rr_arbiter3.sv
// Testbench for rr_arbiter3. Stimulus queues the expected grants (value, length and
// trailing timeout). A monitor on the falling edge assembles the grants the DUT actually
// makes and checks them against that queue.
module tb_rr_arbiter3;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       any_req;
  logic       timeout;

  rr_arbiter3 #(
    .N_REQ   (3),
    .MAX_HOLD(8),
    .CNT_W   (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .owner  (owner),
    .busy   (busy),
    .any_req(any_req),
    .timeout(timeout)
  );

  typedef struct {
    logic [2:0] gnt;
    int         len;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_grant(input logic [2:0] g, input int len, input logic tmo);
    exp_t e;
    e.gnt = g;
    e.len = len;
    e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: build each grant from the gnt stream and score it when it ends.
  logic       mon_in_grant  = 1'b0;
  logic       mon_have_prev = 1'b0;
  logic [2:0] mon_gnt       = 3'b000;
  int         mon_len       = 0;
  int         mon_zero      = 0;

  initial begin
    exp_t e;
    logic [1:0] exp_owner;
    forever begin
      @(negedge clk);
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("busy_eq_any_gnt", 32'(busy), 32'(|gnt));
      if (busy) begin
        exp_owner = (gnt == 3'b010) ? 2'd1 : ((gnt == 3'b100) ? 2'd2 : 2'd0);
        check("owner_matches_gnt", 32'(owner), 32'(exp_owner));
      end
      if (mon_in_grant && gnt == mon_gnt) begin
        mon_len++;
      end else begin
        if (mon_in_grant) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL grant_unexpected: got gnt=%b len=%0d, expected no grant",
                     mon_gnt, mon_len);
          end else begin
            e = exp_q.pop_front();
            check("grant_value", 32'(mon_gnt), 32'(e.gnt));
            check("grant_length", 32'(mon_len), 32'(e.len));
            check("grant_timeout", 32'(timeout), 32'(e.tmo));
          end
          mon_in_grant  = 1'b0;
          mon_have_prev = 1'b1;
          mon_zero      = 0;
        end
        if (gnt != 3'b000) begin
          if (mon_have_prev) check("grant_gap_ge2", 32'(mon_zero >= 2), 32'd1);
          mon_in_grant = 1'b1;
          mon_gnt      = gnt;
          mon_len      = 1;
        end else begin
          mon_zero++;
        end
      end
      if (reset) mon_have_prev = 1'b0;
    end
  end

  initial begin
    // Reset values, then any_req for every request pattern while held in reset.
    reset = 1'b1;
    req   = 3'b111;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_any_req", 32'(any_req), 32'd1);
    for (int v = 0; v < 8; v++) begin
      req = 3'(v);
      #1;
      check("any_req_comb", 32'(any_req), 32'(v != 0));
    end
    tick(1);

    // Single requester, 3-cycle grant with a voluntary release.
    reset = 1'b0;
    req   = 3'b010;
    expect_grant(3'b010, 3, 1'b0);
    tick(1);
    check("latency_1clk", 32'(gnt), 32'b010);
    tick(2);
    req = 3'b000;
    tick(3);

    // From reset, all three requesting: 0,1,2,0, each forced out after 8 cycles.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick(1);
    req = 3'b111;
    expect_grant(3'b001, 8, 1'b1);
    expect_grant(3'b010, 8, 1'b1);
    expect_grant(3'b100, 8, 1'b1);
    expect_grant(3'b001, 8, 1'b1);
    tick(39);
    req = 3'b000;
    tick(3);

    // Owner 0 drops req in its 8th cycle: voluntary release, no timeout. Then client 2.
    req = 3'b001;
    expect_grant(3'b001, 8, 1'b0);
    expect_grant(3'b100, 3, 1'b0);
    tick(8);
    req = 3'b100;
    tick(5);
    req = 3'b000;
    tick(3);

    // A request pulse that clears before any clock edge is not latched.
    req = 3'b001;
    #2;
    req = 3'b000;
    tick(2);
    check("glitch_not_latched", 32'(busy), 32'd0);

    // Asynchronous reset while client 2 owns the grant; afterwards client 0 wins again.
    req = 3'b100;
    expect_grant(3'b100, 2, 1'b0);
    tick(3);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    req = 3'b101;
    tick(1);
    reset = 1'b0;
    expect_grant(3'b001, 2, 1'b0);
    tick(2);
    req = 3'b000;
    tick(3);

    // A sole requester is granted again straight after a forced release.
    req = 3'b010;
    expect_grant(3'b010, 8, 1'b1);
    expect_grant(3'b010, 2, 1'b0);
    tick(12);
    req = 3'b000;
    tick(4);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("no_open_grant", 32'(mon_in_grant), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
